// File: rtl/leaf_stream_pkg.sv
// Shared defaults and bus-slicing helper for the leaf stream buffer.
package leaf_stream_pkg;

  localparam int PAYLOAD_BITS_DEF = 32;
  localparam int COUNT_BITS_DEF   = 16;

  // LSB position of channel k inside a flat bus of width-bit channels.
  function automatic int slice_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// Single-channel first-word-fall-through FIFO with registered ack/valid and a
// synchronous flush; storage is a small register array.
module leaf_stream_fifo
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS    = PAYLOAD_BITS_DEF,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    wr_vld,
  output logic                    wr_ack,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  output logic                    rd_vld,
  input  logic                    rd_ack,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    empty
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int OW    = FIFO_DEPTH_BITS + 1;

  logic [PAYLOAD_BITS-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [OW-1:0]              occ;
  logic [OW-1:0]              occ_nxt;
  logic                       wr_ack_q;
  logic                       rd_vld_q;
  logic                       wr_fire;
  logic                       rd_fire;

  // Flush masks the registered handshakes so nothing moves while it is held.
  assign wr_ack  = wr_ack_q & ~flush;
  assign rd_vld  = rd_vld_q & ~flush;
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;
  assign empty   = ~rd_vld_q;

  assign wr_fire = wr_vld & wr_ack;
  assign rd_fire = rd_ack & rd_vld;

  always_comb begin
    occ_nxt = occ + OW'(wr_fire) - OW'(rd_fire);
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      wr_ack_q <= 1'b0;
      rd_vld_q <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      wr_ack_q <= 1'b1;
      rd_vld_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (rd_fire) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      occ      <= occ_nxt;
      wr_ack_q <= (occ_nxt != OW'(DEPTH));
      rd_vld_q <= (occ_nxt != '0);
    end
  end

  always_ff @(posedge clk_user) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/leaf_stream_buffer.sv
// Buffered bridge between the leaf interface and an HLS kernel: one FIFO per
// channel in each direction, per-channel delivered-word counters and an idle flag.
module leaf_stream_buffer
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS    = PAYLOAD_BITS_DEF,
  parameter int NUM_IN_PORTS    = 2,
  parameter int NUM_OUT_PORTS   = 2,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int COUNT_BITS      = COUNT_BITS_DEF
) (
  input  logic                                clk_user,
  input  logic                                reset_n,
  input  logic                                flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_i2u,
  input  logic [NUM_IN_PORTS-1:0]               vld_i2u,
  output logic [NUM_IN_PORTS-1:0]               ack_i2u,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_user,
  output logic [NUM_IN_PORTS-1:0]               vld_user,
  input  logic [NUM_IN_PORTS-1:0]               ack_user,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_from_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_to_user,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_u2i,
  output logic [NUM_OUT_PORTS-1:0]              vld_u2i,
  input  logic [NUM_OUT_PORTS-1:0]              ack_u2i,
  output logic [NUM_IN_PORTS*COUNT_BITS-1:0]    in_count,
  output logic [NUM_OUT_PORTS*COUNT_BITS-1:0]   out_count,
  output logic                                  idle
);

  logic [NUM_IN_PORTS-1:0]  in_empty;
  logic [NUM_OUT_PORTS-1:0] out_empty;
  logic [COUNT_BITS-1:0]    in_cnt_q  [NUM_IN_PORTS];
  logic [COUNT_BITS-1:0]    out_cnt_q [NUM_OUT_PORTS];

  for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
    leaf_stream_fifo #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_user(clk_user),
      .reset_n (reset_n),
      .flush   (flush),
      .wr_vld  (vld_i2u[k]),
      .wr_ack  (ack_i2u[k]),
      .wr_data (din_i2u[slice_lsb(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .rd_vld  (vld_user[k]),
      .rd_ack  (ack_user[k]),
      .rd_data (dout_user[slice_lsb(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .empty   (in_empty[k])
    );

    // vld_user is already masked by flush, so counters hold during a flush.
    always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
        in_cnt_q[k] <= '0;
      end else if (vld_user[k] && ack_user[k]) begin
        in_cnt_q[k] <= in_cnt_q[k] + COUNT_BITS'(1);
      end
    end

    assign in_count[slice_lsb(k, COUNT_BITS) +: COUNT_BITS] = in_cnt_q[k];
  end

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    leaf_stream_fifo #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_user(clk_user),
      .reset_n (reset_n),
      .flush   (flush),
      .wr_vld  (vld_from_user[k]),
      .wr_ack  (ack_to_user[k]),
      .wr_data (din_user[slice_lsb(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .rd_vld  (vld_u2i[k]),
      .rd_ack  (ack_u2i[k]),
      .rd_data (dout_u2i[slice_lsb(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .empty   (out_empty[k])
    );

    always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
        out_cnt_q[k] <= '0;
      end else if (vld_u2i[k] && ack_u2i[k]) begin
        out_cnt_q[k] <= out_cnt_q[k] + COUNT_BITS'(1);
      end
    end

    assign out_count[slice_lsb(k, COUNT_BITS) +: COUNT_BITS] = out_cnt_q[k];
  end

  assign idle = (&in_empty) & (&out_empty);

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Randomized and directed bench for leaf_stream_buffer against a queue-based
// model; a second instance with 4-bit counters exercises counter wrap.
module tb_leaf_stream_buffer;

  localparam int PB = 32;
  localparam int D  = 4;

  logic        clk_user = 1'b0;
  logic        reset_n  = 1'b0;
  logic        flush    = 1'b0;
  logic [63:0] din_i2u  = '0;
  logic [1:0]  vld_i2u  = '0;
  logic [1:0]  ack_user = '0;
  logic [63:0] din_user = '0;
  logic [1:0]  vld_from_user = '0;
  logic [1:0]  ack_u2i  = '0;

  logic [1:0]  ack_i2u, vld_user, ack_to_user, vld_u2i;
  logic [63:0] dout_user, dout_u2i;
  logic [31:0] in_count, out_count;
  logic        idle;

  logic [1:0]  w_ack_i2u, w_vld_user, w_ack_to_user, w_vld_u2i;
  logic [63:0] w_dout_user, w_dout_u2i;
  logic [7:0]  w_in_count, w_out_count;
  logic        w_idle;

  always #5 clk_user = ~clk_user;

  leaf_stream_buffer dut (
    .clk_user(clk_user), .reset_n(reset_n), .flush(flush),
    .din_i2u(din_i2u), .vld_i2u(vld_i2u), .ack_i2u(ack_i2u),
    .dout_user(dout_user), .vld_user(vld_user), .ack_user(ack_user),
    .din_user(din_user), .vld_from_user(vld_from_user), .ack_to_user(ack_to_user),
    .dout_u2i(dout_u2i), .vld_u2i(vld_u2i), .ack_u2i(ack_u2i),
    .in_count(in_count), .out_count(out_count), .idle(idle)
  );

  leaf_stream_buffer #(.COUNT_BITS(4)) dut_w (
    .clk_user(clk_user), .reset_n(reset_n), .flush(flush),
    .din_i2u(din_i2u), .vld_i2u(vld_i2u), .ack_i2u(w_ack_i2u),
    .dout_user(w_dout_user), .vld_user(w_vld_user), .ack_user(ack_user),
    .din_user(din_user), .vld_from_user(vld_from_user), .ack_to_user(w_ack_to_user),
    .dout_u2i(w_dout_u2i), .vld_u2i(w_vld_u2i), .ack_u2i(ack_u2i),
    .in_count(w_in_count), .out_count(w_out_count), .idle(w_idle)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: one queue per channel, delivered-word counts, and whether an edge
  // has occurred since reset released (write side only accepts after that).
  logic [31:0] qi [2][$];
  logic [31:0] qo [2][$];
  int          cnt_i [2];
  int          cnt_o [2];
  bit          m_live = 0;
  bit          last_wi [2];
  bit          last_wo [2];

  function automatic bit exp_wr_ok(input int size);
    return m_live && (size < D) && !flush;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      qi[k].delete(); qo[k].delete();
      cnt_i[k] = 0; cnt_o[k] = 0;
      last_wi[k] = 0; last_wo[k] = 0;
    end
    m_live = 0;
  endtask

  task automatic check_outputs();
    int total = 0;
    for (int k = 0; k < 2; k++) begin
      bit ev_i = (qi[k].size() > 0) && !flush;
      bit ev_o = (qo[k].size() > 0) && !flush;
      total += qi[k].size() + qo[k].size();
      chk("ack_i2u", ack_i2u[k], exp_wr_ok(qi[k].size()));
      chk("vld_user", vld_user[k], ev_i);
      if (ev_i) chk("dout_user", dout_user[k*PB +: PB], qi[k][0]);
      chk("in_count", in_count[k*16 +: 16], cnt_i[k] % 65536);
      chk("in_count_w", w_in_count[k*4 +: 4], cnt_i[k] % 16);
      chk("ack_to_user", ack_to_user[k], exp_wr_ok(qo[k].size()));
      chk("vld_u2i", vld_u2i[k], ev_o);
      if (ev_o) chk("dout_u2i", dout_u2i[k*PB +: PB], qo[k][0]);
      chk("out_count", out_count[k*16 +: 16], cnt_o[k] % 65536);
      chk("out_count_w", w_out_count[k*4 +: 4], cnt_o[k] % 16);
    end
    chk("idle", idle, total == 0);
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit wi = vld_i2u[k] && exp_wr_ok(qi[k].size());
      bit ri = ack_user[k] && (qi[k].size() > 0) && !flush;
      bit wo = vld_from_user[k] && exp_wr_ok(qo[k].size());
      bit ro = ack_u2i[k] && (qo[k].size() > 0) && !flush;
      last_wi[k] = wi;
      last_wo[k] = wo;
      if (flush) begin
        qi[k].delete(); qo[k].delete();
      end else begin
        if (ri) begin void'(qi[k].pop_front()); cnt_i[k]++; end
        if (ro) begin void'(qo[k].pop_front()); cnt_o[k]++; end
        if (wi) qi[k].push_back(din_i2u[k*PB +: PB]);
        if (wo) qo[k].push_back(din_user[k*PB +: PB]);
      end
    end
    m_live = 1;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk_user);
    model_update();
    @(negedge clk_user);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ack_i2u", ack_i2u, 0);
    chk("rst_ack_to_user", ack_to_user, 0);
    chk("rst_vld_user", vld_user, 0);
    chk("rst_vld_u2i", vld_u2i, 0);
    chk("rst_idle", idle, 1);
    chk("rst_dout_user", dout_user, 0);
    chk("rst_dout_u2i", dout_u2i, 0);
    chk("rst_in_count", in_count, 0);
    chk("rst_out_count", out_count, 0);
    model_clear();
    vld_i2u = '0; vld_from_user = '0; ack_user = '0; ack_u2i = '0; flush = 1'b0;
    repeat (2) @(posedge clk_user);
    @(negedge clk_user);
    reset_n = 1'b1;
  endtask

  task automatic drive_random(input int flush_pct);
    for (int k = 0; k < 2; k++) begin
      if (last_wi[k]) vld_i2u[k] = 1'b0;
      if (!vld_i2u[k] && $urandom_range(0, 99) < 60) begin
        vld_i2u[k] = 1'b1;
        din_i2u[k*PB +: PB] = $urandom();
      end
      if (last_wo[k]) vld_from_user[k] = 1'b0;
      if (!vld_from_user[k] && $urandom_range(0, 99) < 60) begin
        vld_from_user[k] = 1'b1;
        din_user[k*PB +: PB] = $urandom();
      end
      ack_user[k] = ($urandom_range(0, 99) < 50);
      ack_u2i[k]  = ($urandom_range(0, 99) < 50);
    end
    flush = ($urandom_range(0, 99) < flush_pct);
  endtask

  logic [31:0] seen [$];
  int          sent;
  int          guard;

  initial begin
    model_clear();
    @(negedge clk_user);
    do_reset();

    // Reset release: write acks rise on the first edge.
    step();
    chk("rel_ack_i2u", ack_i2u, 2'b11);
    chk("rel_ack_to_user", ack_to_user, 2'b11);
    chk("rel_vld_user", vld_user, 2'b00);
    chk("rel_idle", idle, 1);

    // Latency: one word through input channel 0.
    din_i2u[31:0] = 32'hDEADBEEF; vld_i2u[0] = 1'b1; ack_user[0] = 1'b1;
    step();
    vld_i2u[0] = 1'b0;
    chk("lat_vld", vld_user[0], 1);
    chk("lat_data", dout_user[31:0], 32'hDEADBEEF);
    step();
    chk("lat_count", in_count[15:0], 1);
    chk("lat_idle", idle, 1);

    // Fill input channel 1 with the kernel stalled.
    ack_user = '0;
    for (int w = 1; w <= 4; w++) begin
      vld_i2u[1] = 1'b1; din_i2u[63:32] = w;
      step();
    end
    vld_i2u[1] = 1'b1; din_i2u[63:32] = 5;
    chk("fill_full_ack", ack_i2u[1], 0);
    ack_user[1] = 1'b1;
    guard = 0;
    while (seen.size() < 5 && guard < 30) begin
      if (vld_user[1]) seen.push_back(dout_user[63:32]);
      step();
      if (last_wi[1]) vld_i2u[1] = 1'b0;
      guard++;
    end
    if (guard >= 30) chk("fill_timeout", seen.size(), 5);
    for (int i = 0; i < seen.size(); i++) chk("fill_order", seen[i], i + 1);
    ack_user = '0;

    // Independence: output ch0 blocked, ch1 streams 100 words.
    ack_u2i = 2'b10;
    vld_from_user[0] = 1'b1; din_user[31:0] = 32'hA5A5A5A5;
    sent = 0; guard = 0;
    while (cnt_o[1] < 100 && guard < 400) begin
      vld_from_user[1] = (sent < 100);
      din_user[63:32] = 32'h1000 + sent;
      #1 chk("indep_ack1", ack_to_user[1], 1);
      step();
      if (last_wo[1]) sent++;
      if (last_wo[0]) vld_from_user[0] = 1'b0;
      guard++;
    end
    vld_from_user = '0;
    if (guard >= 400) chk("indep_timeout", cnt_o[1], 100);
    chk("indep_cnt1", out_count[31:16], 100);
    chk("indep_cnt0", out_count[15:0], 0);
    ack_u2i = '0;

    // Flush: three words parked in input ch0.
    for (int w = 0; w < 3; w++) begin
      vld_i2u[0] = 1'b1; din_i2u[31:0] = 32'hF00 + w;
      step();
    end
    vld_i2u[0] = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_vld", vld_user[0], 0);
    chk("flush_idle", idle, 1);
    chk("flush_count", in_count[15:0], 1);
    @(negedge clk_user);

    // Randomized traffic with occasional flush.
    for (int c = 0; c < 2000; c++) begin
      drive_random(3);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of traffic.
    for (int c = 0; c < 20; c++) begin
      drive_random(0);
      ack_user = '0;
      step();
    end
    #2 do_reset();
    step();

    // Counter wrap on the 4-bit instance: 17 transfers on input ch0.
    ack_user[0] = 1'b1;
    sent = 0; guard = 0;
    while (cnt_i[0] < 17 && guard < 100) begin
      vld_i2u[0] = (sent < 17);
      din_i2u[31:0] = 32'h200 + sent;
      step();
      if (last_wi[0]) sent++;
      guard++;
    end
    vld_i2u = '0;
    if (guard >= 100) chk("wrap_timeout", cnt_i[0], 17);
    chk("wrap_count_w", w_in_count[3:0], 1);
    chk("wrap_count", in_count[15:0], 17);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
